behavioural_mux_8x1: RTL and testbench
======================================

Name: behavioural_mux_8x1

Overview:
- Registered 8-to-1 multiplexer: one of eight W-bit data inputs i1..i8 is chosen by three discrete select bits s0..s2 and driven on o after a clock edge.
- Used as a generic routing element in datapaths where a glitch-free, registered, resettable mux output is required.
- Selection logic is purely combinational; only the output stage is clocked.

Parameters:
- W, 1, data width of each input i1..i8 and of output o (W >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- en  input  1  output-register load enable; when low, o holds
- s0  input  1  select bit 0 (LSB)
- s1  input  1  select bit 1
- s2  input  1  select bit 2 (MSB)
- i1..i8  input  W each  data inputs (eight separate ports)
- o  output  W  registered selected data

Behaviour:
- Select index sel = {s2,s1,s0}.
- Mapping: 000->i1, 001->i2, 010->i3, 011->i4, 100->i5, 101->i6, 110->i7, 111->i8.
- Registered output: on each rising clk edge:
  - rst_n==0: o <= 0 (all W bits). Reset has priority over en.
  - else if en==1: o <= selected input.
  - else: o holds its value.
- Latency is 1 cycle from stable s*/i* (with en=1) to o. No combinational path from any input to o.
- o is 0 from the first edge sampled with rst_n low until the first enabled edge after rst_n rises.
- Reset asserted mid-operation clears o at that edge, regardless of s*/i*/en.
- Select and data changes between edges have no effect; only values at the edge matter.
- Select with X/Z is not specified for synthesis. Simulation must propagate X to o, never silently pick i1.
- No handshake, no state machine; the output register is the only state.

Optional Feature:
- Macro: BEHAVIOURAL_MUX_PIPE2_EN
- Defined:
  - A second register stage is added after o's first stage; latency becomes 2 cycles.
  - Both stages reset to 0 synchronously on rst_n==0.
  - en gates both stages together, so data never splits across a stall.
- Undefined: a single stage with 1-cycle latency, as described above.
- Port list is identical in both builds.

Decomposition:
- Package behavioural_mux_pkg:
  - typedef sel_t (3-bit) for the select index.
  - Constants SEL_I1=3'd0 .. SEL_I8=3'd7.
  - Constant MUX_RESET_VAL (all zeros).
  - Constant MUX_LATENCY (1, or 2 under BEHAVIOURAL_MUX_PIPE2_EN).
- One sub-module: mux8_comb.
  - Purely combinational, parameterised by W.
  - Takes sel_t and the eight inputs; produces the selected value.
  - The top adds the enable and reset register stage(s).

Test Plan:
- Reset: rst_n=0 for 2 edges with i1..i8 = all ones, sel=000, en=1 -> o=0 at every edge while rst_n=0; first edge after release -> o=all ones.
- Full sweep, W=1: i1=1, i2..i8=0, en=1; step sel through 000,001,...,111, one per cycle -> o=1 one cycle after sel=000, o=0 for the other seven.
- Walking one, W=8: i_k = 8'h10+k (k=1..8); apply each sel -> one cycle later o = 8'h11 for 000, 8'h12 for 001, ..., 8'h18 for 111.
- Enable hold: sel=011 with i4=8'hA5 and en=1 -> o=8'hA5; then sel=110, i7=8'h3C, en=0 for 3 cycles -> o stays 8'hA5; en=1 -> o=8'h3C next edge.
- Reset mid-stream: o=8'hA5, assert rst_n=0 with en=1 and sel=011 -> o=0 at that edge; release -> o=8'hA5 next edge.
- BEHAVIOURAL_MUX_PIPE2_EN build: repeat the walking-one test -> each value appears on o exactly 2 edges after its select/data is applied; reset clears both stages.

Source files
------------

// File: rtl/behavioural_mux_pkg.sv
// Shared types and constants for the registered 8-to-1 mux.
// BEHAVIOURAL_MUX_PIPE2_EN selects the two-stage output pipeline.
package behavioural_mux_pkg;

    typedef logic [2:0] sel_t;

    localparam sel_t SEL_I1 = 3'd0;
    localparam sel_t SEL_I2 = 3'd1;
    localparam sel_t SEL_I3 = 3'd2;
    localparam sel_t SEL_I4 = 3'd3;
    localparam sel_t SEL_I5 = 3'd4;
    localparam sel_t SEL_I6 = 3'd5;
    localparam sel_t SEL_I7 = 3'd6;
    localparam sel_t SEL_I8 = 3'd7;

    // Single reset bit, replicated to the data width at each register.
    localparam logic MUX_RESET_VAL = 1'b0;

`ifdef BEHAVIOURAL_MUX_PIPE2_EN
    localparam int unsigned MUX_LATENCY = 2;
`else
    localparam int unsigned MUX_LATENCY = 1;
`endif

endpackage

// File: rtl/mux8_comb.sv
// Combinational 8-to-1 selector; an unknown select yields X rather than i1.
module mux8_comb
    import behavioural_mux_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  sel_t         sel,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    input  logic [W-1:0] i4,
    input  logic [W-1:0] i5,
    input  logic [W-1:0] i6,
    input  logic [W-1:0] i7,
    input  logic [W-1:0] i8,
    output logic [W-1:0] y_c
);

    always_comb begin
        y_c = 'x;
        case (sel)
            SEL_I1:  y_c = i1;
            SEL_I2:  y_c = i2;
            SEL_I3:  y_c = i3;
            SEL_I4:  y_c = i4;
            SEL_I5:  y_c = i5;
            SEL_I6:  y_c = i6;
            SEL_I7:  y_c = i7;
            SEL_I8:  y_c = i8;
            default: y_c = 'x;
        endcase
    end

endmodule

// File: rtl/behavioural_mux_8x1.sv
// Registered 8-to-1 mux with load enable and synchronous active-low reset.
// Define BEHAVIOURAL_MUX_PIPE2_EN for a second output stage (2-cycle latency).
module behavioural_mux_8x1
    import behavioural_mux_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         s0,
    input  logic         s1,
    input  logic         s2,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    input  logic [W-1:0] i4,
    input  logic [W-1:0] i5,
    input  logic [W-1:0] i6,
    input  logic [W-1:0] i7,
    input  logic [W-1:0] i8,
    output logic [W-1:0] o
);

    sel_t         sel_c;
    logic [W-1:0] mux_c;
    logic [W-1:0] o_d;
    logic [W-1:0] o_q;

    assign sel_c = {s2, s1, s0};

    mux8_comb #(.W(W)) u_mux (
        .sel (sel_c),
        .i1  (i1),
        .i2  (i2),
        .i3  (i3),
        .i4  (i4),
        .i5  (i5),
        .i6  (i6),
        .i7  (i7),
        .i8  (i8),
        .y_c (mux_c)
    );

`ifdef BEHAVIOURAL_MUX_PIPE2_EN
    logic [W-1:0] p1_d;
    logic [W-1:0] p1_q;

    // Both stages share en so a stall never splits data between them.
    always_comb begin
        p1_d = p1_q;
        o_d  = o_q;
        if (en) begin
            p1_d = mux_c;
            o_d  = p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_q <= {W{MUX_RESET_VAL}};
            o_q  <= {W{MUX_RESET_VAL}};
        end else begin
            p1_q <= p1_d;
            o_q  <= o_d;
        end
    end
`else
    always_comb begin
        o_d = o_q;
        if (en) begin
            o_d = mux_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q <= {W{MUX_RESET_VAL}};
        end else begin
            o_q <= o_d;
        end
    end
`endif

    assign o = o_q;

endmodule

// File: tb/tb_behavioural_mux_8x1.sv
// Directed-vector bench for behavioural_mux_8x1 at W=1 and W=8; latency-aware.
module tb_behavioural_mux_8x1;
    import behavioural_mux_pkg::*;

    localparam int LAT = int'(MUX_LATENCY);

    logic       clk = 1'b0;
    logic       rst_n, en, s0, s1, s2;
    logic [7:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic [7:0] o8;
    logic       b1, b2, b3, b4, b5, b6, b7, b8;
    logic       o1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    behavioural_mux_8x1 #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .s0(s0), .s1(s1), .s2(s2),
        .i1(d1), .i2(d2), .i3(d3), .i4(d4), .i5(d5), .i6(d6), .i7(d7), .i8(d8),
        .o(o8)
    );

    behavioural_mux_8x1 #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .s0(s0), .s1(s1), .s2(s2),
        .i1(b1), .i2(b2), .i3(b3), .i4(b4), .i5(b5), .i6(b6), .i7(b7), .i8(b8),
        .o(o1)
    );

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic set_sel(input int k);
        logic [2:0] v;
        v  = 3'(k);
        s0 = v[0];
        s1 = v[1];
        s2 = v[2];
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; set_sel(0);
        {d1, d2, d3, d4, d5, d6, d7, d8} = {8{8'hFF}};
        {b1, b2, b3, b4, b5, b6, b7, b8} = 8'hFF;

        // Reset holds both widths at zero despite all-ones data and en=1.
        for (int t = 0; t < 2; t++) begin
            tick();
            check_val($sformatf("reset8_%0d", t), o8, 8'h00);
            check_val($sformatf("reset1_%0d", t), {7'd0, o1}, 8'h00);
        end
        rst_n = 1'b1;
        for (int t = 1; t <= LAT; t++) begin
            tick();
            check_val($sformatf("release8_%0d", t), o8, (t >= LAT) ? 8'hFF : 8'h00);
            check_val($sformatf("release1_%0d", t), {7'd0, o1}, (t >= LAT) ? 8'h01 : 8'h00);
        end

        // Clear pipeline before the streaming tests so early samples are known zero.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        {b1, b2, b3, b4, b5, b6, b7, b8} = 8'b1000_0000;
        d1 = 8'h11; d2 = 8'h12; d3 = 8'h13; d4 = 8'h14;
        d5 = 8'h15; d6 = 8'h16; d7 = 8'h17; d8 = 8'h18;
        {b1, b2, b3, b4, b5, b6, b7, b8} = 8'b1000_0000;

        // Select changes every cycle; output trails by LAT edges.
        for (int k = 0; k < 8 + LAT - 1; k++) begin
            int j;
            if (k < 8) set_sel(k);
            tick();
            j = k - LAT + 1;
            check_val($sformatf("walk8_%0d", k), o8, (j < 0) ? 8'h00 : 8'(8'h11 + j));
            check_val($sformatf("sweep1_%0d", k), {7'd0, o1}, (j == 0) ? 8'h01 : 8'h00);
        end

        // Enable hold.
        set_sel(3); d4 = 8'hA5;
        for (int t = 0; t < LAT; t++) tick();
        check_val("hold_load", o8, 8'hA5);
        set_sel(6); d7 = 8'h3C; en = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            check_val($sformatf("hold_%0d", t), o8, 8'hA5);
        end
        en = 1'b1;
        for (int t = 1; t <= LAT; t++) begin
            tick();
            check_val($sformatf("hold_rel_%0d", t), o8, (t >= LAT) ? 8'h3C : 8'hA5);
        end

        // Data glitch between edges has no effect.
        set_sel(3);
        for (int t = 0; t < LAT; t++) tick();
        d4 = 8'hFF;
        #2;
        d4 = 8'hA5;
        tick();
        check_val("glitch", o8, 8'hA5);

        // Reset mid-stream wins over en and clears every stage.
        rst_n = 1'b0;
        tick();
        check_val("mid_reset", o8, 8'h00);
        rst_n = 1'b1;
        for (int t = 1; t <= LAT; t++) begin
            tick();
            check_val($sformatf("mid_rel_%0d", t), o8, (t >= LAT) ? 8'hA5 : 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
